// File: rtl/moldudp64_pkg.sv
// Shared types and width defaults for the MoldUDP64 receive path.
// Used by the feed arbiter and the decoder.
package moldudp64_pkg;

    localparam int unsigned MOLD_AXI_DATA_W = 64;
    localparam int unsigned MOLD_AXI_KEEP_W = MOLD_AXI_DATA_W / 8;
    localparam int unsigned MOLD_CNT_W      = 32;

    localparam logic FEED_A = 1'b0;
    localparam logic FEED_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } arb_state_e;

    // Round-robin helper: the feed that gets priority after `f` completes a packet.
    function automatic logic other_feed(input logic f);
        return ~f;
    endfunction

endpackage

// File: rtl/moldudp64_feed_arb_if.sv
// AXI-stream bundle for one UDP/MoldUDP64 feed or the merged decoder port.
interface moldudp64_feed_arb_if
    import moldudp64_pkg::*;
#(
    parameter int unsigned DATA_W = MOLD_AXI_DATA_W,
    parameter int unsigned KEEP_W = DATA_W / 8
);
    logic              tvalid;
    logic              tready;
    logic [KEEP_W-1:0] tkeep;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tuser;

    modport master (
        output tvalid, tkeep, tdata, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tkeep, tdata, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/moldudp64_feed_arb_axis_pipe_reg.sv
// One-stage registered AXI-stream slice; payload is an opaque W-bit vector.
// Ingress ready is combinational: free slot or draining this cycle.
module axis_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready_c,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready_c = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready_c) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/moldudp64_feed_arb.sv
// Packet-level round-robin merge of redundant A/B MoldUDP64 feeds into one
// decoder port, with per-feed enables and forwarded-packet counters.
module moldudp64_feed_arb
    import moldudp64_pkg::*;
#(
    parameter int unsigned AXI_DATA_W = MOLD_AXI_DATA_W,
    parameter int unsigned AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int unsigned CNT_W      = MOLD_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           feed_en_i,
    moldudp64_feed_arb_if.slave  udp_a_axis,
    moldudp64_feed_arb_if.slave  udp_b_axis,
    moldudp64_feed_arb_if.master mold_axis,
    output logic                 mold_axis_src_o,
    output logic [CNT_W-1:0]     pkt_cnt_a_o,
    output logic [CNT_W-1:0]     pkt_cnt_b_o
);

    localparam int unsigned OFS_KEEP = AXI_DATA_W;
    localparam int unsigned OFS_LAST = AXI_DATA_W + AXI_KEEP_W;
    localparam int unsigned OFS_USER = OFS_LAST + 1;
    localparam int unsigned OFS_SRC  = OFS_LAST + 2;
    localparam int unsigned PAY_W    = OFS_LAST + 3;

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_rr;
    logic             w_rr_nxt;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    logic             w_cand_a;
    logic             w_cand_b;
    logic             w_grant;
    logic             w_sel;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic             w_accept;
    logic             w_done;
    logic             w_pipe_rdy;
    logic             w_ingress_rdy;
    logic [PAY_W-1:0] w_pay_in;
    logic [PAY_W-1:0] w_pay_out;

    // Enables only matter when choosing a new packet; a locked packet always finishes.
    assign w_cand_a      = udp_a_axis.tvalid && feed_en_i[0];
    assign w_cand_b      = udp_b_axis.tvalid && feed_en_i[1];
    assign w_ingress_rdy = w_pipe_rdy && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rr    <= FEED_A;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_grant     = 1'b0;
        w_sel       = r_rr;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_cand_a && w_cand_b) begin
                    w_grant = 1'b1;
                    w_sel   = r_rr;
                end else if (w_cand_a) begin
                    w_grant = 1'b1;
                    w_sel   = FEED_A;
                end else if (w_cand_b) begin
                    w_grant = 1'b1;
                    w_sel   = FEED_B;
                end
            end
            ST_LOCK_A: begin
                w_grant = 1'b1;
                w_sel   = FEED_A;
            end
            ST_LOCK_B: begin
                w_grant = 1'b1;
                w_sel   = FEED_B;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_sel_valid = (w_sel == FEED_B) ? udp_b_axis.tvalid : udp_a_axis.tvalid;
        w_sel_last  = (w_sel == FEED_B) ? udp_b_axis.tlast  : udp_a_axis.tlast;
        w_accept    = w_grant && w_ingress_rdy && w_sel_valid;

        // A single-beat packet completes straight from IDLE without locking.
        if (w_accept) begin
            if (w_sel_last) begin
                w_state_nxt = ST_IDLE;
                w_rr_nxt    = other_feed(w_sel);
                w_done      = 1'b1;
            end else begin
                w_state_nxt = (w_sel == FEED_B) ? ST_LOCK_B : ST_LOCK_A;
            end
        end
    end

    assign udp_a_axis.tready = w_grant && (w_sel == FEED_A) && w_ingress_rdy;
    assign udp_b_axis.tready = w_grant && (w_sel == FEED_B) && w_ingress_rdy;

    assign w_pay_in = (w_sel == FEED_B)
        ? {w_sel, udp_b_axis.tuser, udp_b_axis.tlast, udp_b_axis.tkeep, udp_b_axis.tdata}
        : {w_sel, udp_a_axis.tuser, udp_a_axis.tlast, udp_a_axis.tkeep, udp_a_axis.tdata};

    axis_pipe_reg #(
        .W (PAY_W)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (w_accept),
        .i_data    (w_pay_in),
        .o_ready_c (w_pipe_rdy),
        .o_valid   (mold_axis.tvalid),
        .o_data    (w_pay_out),
        .i_ready   (mold_axis.tready)
    );

    assign mold_axis.tdata = w_pay_out[AXI_DATA_W-1:0];
    assign mold_axis.tkeep = w_pay_out[OFS_KEEP +: AXI_KEEP_W];
    assign mold_axis.tlast = w_pay_out[OFS_LAST];
    assign mold_axis.tuser = w_pay_out[OFS_USER];
    assign mold_axis_src_o = w_pay_out[OFS_SRC];

    // Counters bump on the tlast handshake so they show up with the output tlast beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (w_done) begin
            if (w_sel == FEED_B) begin
                r_cnt_b <= r_cnt_b + CNT_W'(1);
            end else begin
                r_cnt_a <= r_cnt_a + CNT_W'(1);
            end
        end
    end

    assign pkt_cnt_a_o = r_cnt_a;
    assign pkt_cnt_b_o = r_cnt_b;

endmodule

// File: tb/tb_moldudp64_feed_arb.sv
// Scoreboard bench for moldudp64_feed_arb: packet-level round-robin model,
// randomized payloads, lengths, gaps and decoder backpressure.
`timescale 1ns/1ps
module tb_moldudp64_feed_arb;
    import moldudp64_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned KW = 8;

    typedef struct packed {
        logic          user;
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic  src;
        beat_t b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] feed_en;
    logic       src1, src2;
    logic [31:0] cnt_a, cnt_b;
    logic [1:0]  cnt2_a, cnt2_b;

    always #5 clk = ~clk;

    moldudp64_feed_arb_if #(.DATA_W(DW), .KEEP_W(KW)) a_if ();
    moldudp64_feed_arb_if #(.DATA_W(DW), .KEEP_W(KW)) b_if ();
    moldudp64_feed_arb_if #(.DATA_W(DW), .KEEP_W(KW)) m_if ();
    moldudp64_feed_arb_if #(.DATA_W(DW), .KEEP_W(KW)) a2_if ();
    moldudp64_feed_arb_if #(.DATA_W(DW), .KEEP_W(KW)) b2_if ();
    moldudp64_feed_arb_if #(.DATA_W(DW), .KEEP_W(KW)) m2_if ();

    moldudp64_feed_arb #(.AXI_DATA_W(DW), .AXI_KEEP_W(KW), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .feed_en_i(feed_en),
        .udp_a_axis(a_if), .udp_b_axis(b_if), .mold_axis(m_if),
        .mold_axis_src_o(src1), .pkt_cnt_a_o(cnt_a), .pkt_cnt_b_o(cnt_b));

    // Narrow-counter instance sees identical stimulus; only its counters are checked.
    moldudp64_feed_arb #(.AXI_DATA_W(DW), .AXI_KEEP_W(KW), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .feed_en_i(feed_en),
        .udp_a_axis(a2_if), .udp_b_axis(b2_if), .mold_axis(m2_if),
        .mold_axis_src_o(src2), .pkt_cnt_a_o(cnt2_a), .pkt_cnt_b_o(cnt2_b));

    assign a2_if.tvalid = a_if.tvalid;
    assign a2_if.tkeep  = a_if.tkeep;
    assign a2_if.tdata  = a_if.tdata;
    assign a2_if.tlast  = a_if.tlast;
    assign a2_if.tuser  = a_if.tuser;
    assign b2_if.tvalid = b_if.tvalid;
    assign b2_if.tkeep  = b_if.tkeep;
    assign b2_if.tdata  = b_if.tdata;
    assign b2_if.tlast  = b_if.tlast;
    assign b2_if.tuser  = b_if.tuser;
    assign m2_if.tready = m_if.tready;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t  exp_q[$];
    beat_t qa_drv[$], qb_drv[$];
    beat_t pa_beats[$], pb_beats[$];
    int    pa_len[$], pb_len[$];
    bit    m_rr = FEED_A;
    int unsigned m_cnt_a = 0, m_cnt_b = 0;

    bit mon_en = 1'b0, chk_a_rdy0 = 1'b0, chk_b_rdy0 = 1'b0;
    bit rdy_rand = 1'b0;
    bit rdy_pat[$];
    int in_first = -1, out_first = -1, out_last = -1;
    int b_sent = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_feed(input bit fb, input bit v, input beat_t bt);
        if (fb) begin
            b_if.tvalid = v; b_if.tdata = bt.data; b_if.tkeep = bt.keep;
            b_if.tlast = bt.last; b_if.tuser = bt.user;
        end else begin
            a_if.tvalid = v; a_if.tdata = bt.data; a_if.tkeep = bt.keep;
            a_if.tlast = bt.last; a_if.tuser = bt.user;
        end
    endtask

    task automatic add_pkt(input bit fb, input int len, input bit fixed);
        beat_t bt;
        for (int i = 0; i < len; i++) begin
            bt.data = {$urandom, $urandom};
            bt.last = (i == len - 1);
            bt.keep = bt.last ? 8'($urandom_range(1, 255)) : 8'hFF;
            bt.user = ($urandom_range(0, 7) == 0);
            if (fixed) begin
                bt.user = 1'b0;
                if (i == 0) bt.data = 64'hDEADBEEF_0000_0000;
                if (i == 1) bt.data = 64'hF0F0F0F0_F0F0F0F0;
                if (i == 2) bt.data = {16'd3, bt.data[47:0]};
            end
            if (fb) begin qb_drv.push_back(bt); pb_beats.push_back(bt); end
            else    begin qa_drv.push_back(bt); pa_beats.push_back(bt); end
        end
        if (fb) pb_len.push_back(len); else pa_len.push_back(len);
    endtask

    // Whole packets, alternating while both feeds have one waiting.
    task automatic predict();
        bit pick;
        int n;
        exp_t e;
        while (pa_len.size() > 0 || pb_len.size() > 0) begin
            if (pa_len.size() > 0 && pb_len.size() > 0) pick = m_rr;
            else pick = (pb_len.size() > 0) ? FEED_B : FEED_A;
            n = pick ? pb_len.pop_front() : pa_len.pop_front();
            for (int i = 0; i < n; i++) begin
                e.src = pick;
                e.b   = pick ? pb_beats.pop_front() : pa_beats.pop_front();
                exp_q.push_back(e);
            end
            if (pick) m_cnt_b++; else m_cnt_a++;
            m_rr = ~pick;
        end
    endtask

    task automatic drive(input bit fb, input bit gaps);
        beat_t bt;
        bit first = 1'b1;
        bit hs;
        int to;
        while ((fb ? qb_drv.size() : qa_drv.size()) > 0) begin
            bt = fb ? qb_drv.pop_front() : qa_drv.pop_front();
            if (!first && gaps) begin
                set_feed(fb, 1'b0, bt);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            set_feed(fb, 1'b1, bt);
            if (fb) b_sent++;
            to = 0;
            forever begin
                @(negedge clk);
                hs = fb ? b_if.tready : a_if.tready;
                if (hs && in_first < 0) in_first = cyc;
                @(posedge clk); #1;
                if (hs) break;
                if (++to > 3000) begin
                    $display("FAIL drive_timeout: feed %0d beat never accepted", fb);
                    $fatal(1);
                end
            end
            first = bt.last;
        end
        set_feed(fb, 1'b0, beat_t'(0));
    endtask

    task automatic drain_and_count(input string name);
        int to = 0;
        while (exp_q.size() > 0 && to < 5000) begin @(posedge clk); to++; end
        chk({name, "_drain"}, 128'(exp_q.size()), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_cnt_a"}, 128'(cnt_a), 128'(m_cnt_a));
        chk({name, "_cnt_b"}, 128'(cnt_b), 128'(m_cnt_b));
        chk({name, "_cnt2_a"}, 128'(cnt2_a), 128'(m_cnt_a % 4));
    endtask

    task automatic run_phase(input bit gaps, input string name);
        in_first = -1; out_first = -1; out_last = -1;
        predict();
        fork
            drive(FEED_A, gaps);
            drive(FEED_B, gaps);
        join
        drain_and_count(name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_rr = FEED_A; m_cnt_a = 0; m_cnt_b = 0;
        exp_q.delete();
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_pat.size() > 0) m_if.tready = rdy_pat.pop_front();
            else if (rdy_rand)      m_if.tready = ($urandom_range(0, 3) != 0);
            else                    m_if.tready = 1'b1;
        end
    end

    // Scoreboard monitor plus stall/ready properties, sampled mid-cycle.
    logic [74:0] cur_pay, prev_pay;
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cur_pay = {src1, m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata};
        if (mon_en && !reset) begin
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: actual=%0h required=none", cur_pay);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", 128'(cur_pay), 128'(e));
                end
                if (out_first < 0) out_first = cyc;
                out_last = cyc;
            end
            if (prev_stall) chk("stall_hold", 128'({m_if.tvalid, cur_pay}), 128'({1'b1, prev_pay}));
            if (m_if.tvalid && !m_if.tready)
                chk("stall_in_rdy", 128'({a_if.tready, b_if.tready}), 128'(0));
            if (chk_b_rdy0) chk("b_rdy_idle", 128'(b_if.tready), 128'(0));
            if (chk_a_rdy0) chk("a_rdy_disabled", 128'(a_if.tready), 128'(0));
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_pay   = cur_pay;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        beat_t junk;
        int to;
        junk.data = 64'h1234_5678_9ABC_DEF0; junk.keep = 8'hA5;
        junk.last = 1'b0; junk.user = 1'b1;
        reset = 1'b1;
        feed_en = 2'b11;
        set_feed(FEED_A, 1'b1, junk);
        set_feed(FEED_B, 1'b1, junk);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 128'(m_if.tvalid), 128'(0));
        chk("rst_tlast", 128'(m_if.tlast), 128'(0));
        chk("rst_tuser", 128'(m_if.tuser), 128'(0));
        chk("rst_tdata", 128'({m_if.tkeep, m_if.tdata}), 128'(0));
        chk("rst_src", 128'(src1), 128'(0));
        chk("rst_cnt", 128'({cnt_a, cnt_b}), 128'(0));
        chk("rst_in_rdy", 128'({a_if.tready, b_if.tready}), 128'(0));
        set_feed(FEED_A, 1'b0, beat_t'(0));
        set_feed(FEED_B, 1'b0, beat_t'(0));
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single feed, fixed header packet.
        chk_b_rdy0 = 1'b1;
        add_pkt(FEED_A, 8, 1'b1);
        run_phase(1'b0, "single");
        chk_b_rdy0 = 1'b0;
        chk("single_latency", 128'(out_first - in_first), 128'(1));

        // Contention right after reset: A first, then B with no bubble.
        do_reset();
        add_pkt(FEED_A, 8, 1'b0);
        add_pkt(FEED_B, 8, 1'b0);
        run_phase(1'b0, "contend");
        chk("contend_contig", 128'(out_last - out_first), 128'(15));

        // Round-robin: three A packets against one pending B packet.
        rdy_rand = 1'b1;
        for (int i = 0; i < 3; i++) add_pkt(FEED_A, $urandom_range(1, 8), 1'b0);
        add_pkt(FEED_B, $urandom_range(1, 8), 1'b0);
        run_phase(1'b1, "rr");
        rdy_rand = 1'b0;

        // Decoder backpressure inside a packet.
        for (int i = 0; i < 10; i++) rdy_pat.push_back(i != 3 && i != 4 && i != 7);
        add_pkt(FEED_A, 6, 1'b0);
        run_phase(1'b0, "bp");

        // Enable only B, drop B's enable mid-packet; A stays pending until re-enabled.
        feed_en = 2'b10;
        b_sent = 0;
        add_pkt(FEED_B, 8, 1'b0);
        predict();
        add_pkt(FEED_A, 5, 1'b0);
        fork
            drive(FEED_A, 1'b0);
        join_none
        fork
            drive(FEED_B, 1'b0);
            begin
                to = 0;
                while (b_sent < 3 && to < 500) begin @(posedge clk); #2; to++; end
                feed_en = 2'b00;
            end
        join
        chk_a_rdy0 = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("en_b_only_done", 128'(exp_q.size()), 128'(0));
        chk("en_cnt_b", 128'(cnt_b), 128'(m_cnt_b));
        chk_a_rdy0 = 1'b0;
        feed_en = 2'b01;
        predict();
        wait fork;
        drain_and_count("en_a");
        feed_en = 2'b11;

        // Randomized mixes.
        for (int it = 0; it < 8; it++) begin
            logic [1:0] en;
            en = 2'($urandom_range(1, 3));
            feed_en = en;
            rdy_rand = $urandom_range(0, 1);
            if (en[0]) repeat ($urandom_range(1, 4)) add_pkt(FEED_A, $urandom_range(1, 8), 1'b0);
            if (en[1]) repeat ($urandom_range(1, 4)) add_pkt(FEED_B, $urandom_range(1, 8), 1'b0);
            run_phase($urandom_range(0, 1), "rand");
        end
        rdy_rand = 1'b0;
        feed_en = 2'b11;
        @(posedge clk); #1;

        // Reset mid-packet clears everything the next cycle.
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            junk.data = {$urandom, $urandom};
            set_feed(FEED_A, 1'b1, junk);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_tvalid", 128'(m_if.tvalid), 128'(0));
        chk("mid_rst_fields", 128'({m_if.tlast, m_if.tuser, src1, m_if.tkeep, m_if.tdata}), 128'(0));
        chk("mid_rst_cnt", 128'({cnt_a, cnt_b}), 128'(0));
        chk("mid_rst_in_rdy", 128'(a_if.tready), 128'(0));
        set_feed(FEED_A, 1'b0, beat_t'(0));
        do_reset();
        mon_en = 1'b1;

        // Narrow counter wraps: five A packets leave a 2-bit counter at 1.
        for (int i = 0; i < 5; i++) add_pkt(FEED_A, $urandom_range(1, 4), 1'b0);
        run_phase(1'b0, "wrap");
        chk("wrap_cnt2_a", 128'(cnt2_a), 128'(1));
        chk("wrap_cnt_a", 128'(cnt_a), 128'(5));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/moldudp64_feed_arb.md
# moldudp64_feed_arb

Packet-level arbiter that merges two redundant UDP/MoldUDP64 AXI-stream feeds (A and B lines) into the single upstream port of the `moldudp64` decoder. It grants one feed at a time, holds the grant until that packet's `tlast` beat is accepted, and alternates round-robin between feeds when both have a packet waiting. It sits between the UDP stripping logic and `moldudp64`. It also carries per-feed enables and forwarded-packet counters for software.

## Interface
- `AXI_DATA_W`, 64, stream data width
- `AXI_KEEP_W`, `AXI_DATA_W/8`, byte keep width
- `CNT_W`, 32, width of the per-feed packet counters
- `clk` in 1 clock
- `reset` in 1 synchronous, active-high reset
- `feed_en_i` in 2 bit0 = feed A, bit1 = feed B; a disabled feed is never granted
- `udp_a_axis_tvalid_i/tkeep_i/tdata_i/tlast_i/tuser_i` in 1/`AXI_KEEP_W`/`AXI_DATA_W`/1/1 feed A stream
- `udp_a_axis_tready_o` out 1 feed A ready
- `udp_b_axis_*` same set as feed A, for feed B
- `mold_axis_tvalid_o/tkeep_o/tdata_o/tlast_o/tuser_o` out 1/`AXI_KEEP_W`/`AXI_DATA_W`/1/1 merged stream to `moldudp64`
- `mold_axis_tready_i` in 1 decoder ready (`udp_axis_tready_o` of `moldudp64`)
- `mold_axis_src_o` out 1 source of the current output beat: 0 = A, 1 = B
- `pkt_cnt_a_o`, `pkt_cnt_b_o` out `CNT_W` count of packets forwarded per feed

## Operation
- FSM states: IDLE, LOCK_A, LOCK_B. Round-robin pointer `rr` names the feed that has priority next; reset value A.
- IDLE: a feed is a candidate when its tvalid and feed_en bit are both 1. The grant is combinational in IDLE.
  - One candidate: that feed is granted.
  - Two candidates: feed `rr` is granted.
  - Granted feed gets tready = ingress ready. The other feed gets tready = 0.
- A beat accepted from feed X while in IDLE:
  - Not tlast: go to LOCK_X.
  - tlast (single-beat packet): stay IDLE; packet is complete.
- LOCK_X: only feed X is ready. The other feed's tready = 0. feed_en is ignored.
  - On accepted tlast from X: go to IDLE.
- Packet completion from feed X: `rr` becomes the other feed, and `pkt_cnt_x` increments by 1. The counter wraps modulo 2^`CNT_W`.
- feed_en is sampled only at packet start. Clearing it mid-packet does not truncate the packet.
- Output register stage: one stage holds valid, keep, data, last, user and src.
  - Ingress ready = `!mold_axis_tvalid_o || mold_axis_tready_i`.
  - The stage loads when an ingress beat is accepted.
  - The stage clears valid when it drains and no new beat arrives.
- tkeep, tdata and tuser pass through unchanged. A packet with tuser = 1 is still forwarded and still counted; the decoder handles errors.
- Reset values: all tready_o = 0, `mold_axis_tvalid_o` = 0, `mold_axis_tlast_o` = 0, `mold_axis_tuser_o` = 0, `mold_axis_src_o` = 0, keep/data = 0, counters = 0, state IDLE, `rr` = A.
- Reset mid-packet drops the partial packet with no tlast emitted. The downstream `moldudp64` shares the same reset.

## Timing
- Latency: 1 cycle from input handshake to `mold_axis_tvalid_o`.
- Full throughput: back-to-back beats at 1 beat/cycle while `mold_axis_tready_i` = 1.
- Zero idle cycles between packets: a new packet's first beat may be accepted in the cycle after the previous tlast is accepted.
- Decoder stall: with the output valid and `mold_axis_tready_i` = 0, all input treadys are 0 and the output holds stable.
- Counters update in the cycle after the tlast handshake, i.e. visible together with the output tlast beat.

## Structure
- Shared package `moldudp64_pkg`:
  - FSM state enum `arb_state_e`.
  - Feed index constants `FEED_A = 1'b0`, `FEED_B = 1'b1`.
  - Width parameter defaults shared with `moldudp64`.
- One natural sub-module: `axis_pipe_reg`, the one-stage registered AXI-stream slice carrying {keep, data, last, user, src}. It is reusable elsewhere in the codebase.
- Arbitration FSM, `rr` pointer and counters live in the top module.

## Test plan
- Single feed: A sends the 8-beat packet (header sid `0xDEADBEEF`, seq `0xF0F0F0F0F0F0F0F0`, 3 msgs), B idle, mold tready = 1.
  - Required: 8 identical output beats 1 cycle late, src = 0, `pkt_cnt_a_o` = 1, B tready = 0 throughout.
- Contention: A and B both assert valid in the same cycle after reset.
  - Required: A granted first; B is granted the cycle after A's tlast is accepted.
  - Required: output shows 8 A beats then 8 B beats contiguous; counters 1/1.
- Round-robin: A sends 3 packets continuously while B holds a packet pending.
  - Required: order A, B, A, A, with no feed starved.
- Backpressure: mold tready toggles 1,0,0,1 during a packet.
  - Required: no beat lost or duplicated; output is stable while stalled; input tready is 0 during the stall.
- Enable: `feed_en_i` = 2'b10 with both feeds valid.
  - Required: only B is forwarded.
  - Then clear bit1 during B's beat 3: B's packet completes with all 8 beats, and B is not granted afterwards.
- Reset/wrap: assert reset mid-packet.
  - Required: every output at its reset value the next cycle.
  - Separately, with `CNT_W` = 2, forward 5 packets on A: `pkt_cnt_a_o` reads 1.
